// File: rtl/gpc_1_5_frame_accumulator_if.sv
// Beat-in / frame-result-out bus of the (1,5;3) GPC frame accumulator.
// The master side drives beats and accepts results; the slave is the accumulator.
interface gpc_1_5_frame_accumulator_if #(
  parameter int unsigned SUM_W = 16,
  parameter int unsigned CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_z;
  logic             in_last;
  logic             in_clear;
  logic             out_valid;
  logic             out_ready;
  logic [SUM_W-1:0] out_sum;
  logic [CNT_W-1:0] out_beats;
  logic             out_ovf;

  modport master (
    output in_valid, in_z, in_last, in_clear, out_ready,
    input  in_ready, out_valid, out_sum, out_beats, out_ovf
  );

  modport slave (
    input  in_valid, in_z, in_last, in_clear, out_ready,
    output in_ready, out_valid, out_sum, out_beats, out_ovf
  );
endinterface

// File: rtl/gpc_1_5_frame_accumulator.sv
// Accumulates 3-bit GPC counts over a frame and presents the total, beat count
// and overflow flag on a valid/ready result port held until accepted.
module gpc_1_5_frame_accumulator #(
  parameter int unsigned SUM_W    = 16,
  parameter int unsigned CNT_W    = 8,
  parameter bit          SATURATE = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  gpc_1_5_frame_accumulator_if.slave io_bus
);

  localparam int unsigned NSUM_W = SUM_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  state_e             r_state;
  state_e             w_state_nxt;

  logic [SUM_W-1:0]   r_acc,       w_acc_nxt;
  logic [CNT_W-1:0]   r_beats,     w_beats_nxt;
  logic               r_ovf,       w_ovf_nxt;
  logic [SUM_W-1:0]   r_out_sum,   w_out_sum_nxt;
  logic [CNT_W-1:0]   r_out_beats, w_out_beats_nxt;
  logic               r_out_ovf,   w_out_ovf_nxt;
  logic               r_in_ready,  w_in_ready_nxt;
  logic               r_out_valid, w_out_valid_nxt;

  logic               w_accept;
  logic [NSUM_W-1:0]  w_nsum;
  logic               w_ovf_upd;
  logic [SUM_W-1:0]   w_sum_upd;
  logic [CNT_W-1:0]   w_beats_upd;

  // acc/beats/ovf are zero in IDLE, so the same update covers a frame's first beat
  assign w_accept    = io_bus.in_valid & r_in_ready;
  assign w_nsum      = {1'b0, r_acc} + NSUM_W'(io_bus.in_z);
  assign w_ovf_upd   = w_nsum[SUM_W] | r_ovf;
  assign w_sum_upd   = (SATURATE && w_ovf_upd) ? {SUM_W{1'b1}} : w_nsum[SUM_W-1:0];
  assign w_beats_upd = (r_beats == {CNT_W{1'b1}}) ? r_beats : r_beats + CNT_W'(1);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_beats     <= '0;
      r_ovf       <= 1'b0;
      r_out_sum   <= '0;
      r_out_beats <= '0;
      r_out_ovf   <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_beats     <= w_beats_nxt;
      r_ovf       <= w_ovf_nxt;
      r_out_sum   <= w_out_sum_nxt;
      r_out_beats <= w_out_beats_nxt;
      r_out_ovf   <= w_out_ovf_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  // Next-state: clear beats last; HOLD leaves only on out_ready
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_ACCUM: begin
        if (io_bus.in_clear) begin
          w_state_nxt = S_IDLE;
        end else if (w_accept) begin
          w_state_nxt = io_bus.in_last ? S_HOLD : S_ACCUM;
        end
      end
      S_HOLD: begin
        if (io_bus.out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath and handshake next values; handshake flags decode the next state
  always_comb begin
    w_acc_nxt       = r_acc;
    w_beats_nxt     = r_beats;
    w_ovf_nxt       = r_ovf;
    w_out_sum_nxt   = r_out_sum;
    w_out_beats_nxt = r_out_beats;
    w_out_ovf_nxt   = r_out_ovf;
    w_in_ready_nxt  = (w_state_nxt != S_HOLD);
    w_out_valid_nxt = (w_state_nxt == S_HOLD);
    case (r_state)
      S_IDLE, S_ACCUM: begin
        if (io_bus.in_clear) begin
          w_acc_nxt   = '0;
          w_beats_nxt = '0;
          w_ovf_nxt   = 1'b0;
        end else if (w_accept) begin
          if (io_bus.in_last) begin
            w_out_sum_nxt   = w_sum_upd;
            w_out_beats_nxt = w_beats_upd;
            w_out_ovf_nxt   = w_ovf_upd;
          end else begin
            w_acc_nxt   = w_sum_upd;
            w_beats_nxt = w_beats_upd;
            w_ovf_nxt   = w_ovf_upd;
          end
        end
      end
      S_HOLD: begin
        if (io_bus.out_ready) begin
          w_acc_nxt   = '0;
          w_beats_nxt = '0;
          w_ovf_nxt   = 1'b0;
        end
      end
      default: begin
        w_acc_nxt   = '0;
        w_beats_nxt = '0;
        w_ovf_nxt   = 1'b0;
      end
    endcase
  end

  assign io_bus.in_ready  = r_in_ready;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.out_sum   = r_out_sum;
  assign io_bus.out_beats = r_out_beats;
  assign io_bus.out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_gpc_1_5_frame_accumulator.sv
// Four accumulator configurations driven in lockstep; per-instance scoreboards
// hold hand-computed frame results popped on each output handshake.
module tb_gpc_1_5_frame_accumulator;

  typedef struct {
    logic [15:0] sum;
    logic [7:0]  beats;
    logic        ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  exp_t q_m[$];
  exp_t q_s[$];
  exp_t q_w[$];
  exp_t q_c[$];

  gpc_1_5_frame_accumulator_if #(.SUM_W(16), .CNT_W(8)) if_m ();
  gpc_1_5_frame_accumulator_if #(.SUM_W(4),  .CNT_W(8)) if_s ();
  gpc_1_5_frame_accumulator_if #(.SUM_W(4),  .CNT_W(8)) if_w ();
  gpc_1_5_frame_accumulator_if #(.SUM_W(16), .CNT_W(2)) if_c ();

  gpc_1_5_frame_accumulator #(.SUM_W(16), .CNT_W(8), .SATURATE(1'b1)) dut_m (.clk(clk), .rst_n(rst_n), .io_bus(if_m));
  gpc_1_5_frame_accumulator #(.SUM_W(4),  .CNT_W(8), .SATURATE(1'b1)) dut_s (.clk(clk), .rst_n(rst_n), .io_bus(if_s));
  gpc_1_5_frame_accumulator #(.SUM_W(4),  .CNT_W(8), .SATURATE(1'b0)) dut_w (.clk(clk), .rst_n(rst_n), .io_bus(if_w));
  gpc_1_5_frame_accumulator #(.SUM_W(16), .CNT_W(2), .SATURATE(1'b1)) dut_c (.clk(clk), .rst_n(rst_n), .io_bus(if_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input int s, input int b, input int o);
    exp_t e;
    e.sum   = 16'(s);
    e.beats = 8'(b);
    e.ovf   = 1'(o);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic score(input string tag, input int qn, input exp_t e,
                       input logic [15:0] s, input logic [7:0] b, input logic o);
    if (qn == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_unexpected: got out_valid=1 sum=%0d expected no result", tag, s);
    end else begin
      chk({tag, "_sum"},   32'(s), 32'(e.sum));
      chk({tag, "_beats"}, 32'(b), 32'(e.beats));
      chk({tag, "_ovf"},   32'(o), 32'(e.ovf));
    end
  endtask

  // Monitors: pop and compare on every accepted result
  always @(negedge clk) begin : mon_m
    exp_t e; int n;
    if (rst_n && if_m.out_valid && if_m.out_ready) begin
      n = q_m.size(); e = mk(0, 0, 0);
      if (n > 0) e = q_m.pop_front();
      score("m", n, e, 16'(if_m.out_sum), 8'(if_m.out_beats), if_m.out_ovf);
    end
  end
  always @(negedge clk) begin : mon_s
    exp_t e; int n;
    if (rst_n && if_s.out_valid && if_s.out_ready) begin
      n = q_s.size(); e = mk(0, 0, 0);
      if (n > 0) e = q_s.pop_front();
      score("s", n, e, 16'(if_s.out_sum), 8'(if_s.out_beats), if_s.out_ovf);
    end
  end
  always @(negedge clk) begin : mon_w
    exp_t e; int n;
    if (rst_n && if_w.out_valid && if_w.out_ready) begin
      n = q_w.size(); e = mk(0, 0, 0);
      if (n > 0) e = q_w.pop_front();
      score("w", n, e, 16'(if_w.out_sum), 8'(if_w.out_beats), if_w.out_ovf);
    end
  end
  always @(negedge clk) begin : mon_c
    exp_t e; int n;
    if (rst_n && if_c.out_valid && if_c.out_ready) begin
      n = q_c.size(); e = mk(0, 0, 0);
      if (n > 0) e = q_c.pop_front();
      score("c", n, e, 16'(if_c.out_sum), 8'(if_c.out_beats), if_c.out_ovf);
    end
  end

  task automatic push_exp(input exp_t m, input exp_t s, input exp_t w, input exp_t c);
    q_m.push_back(m);
    q_s.push_back(s);
    q_w.push_back(w);
    q_c.push_back(c);
  endtask

  task automatic drive(input logic v, input logic [2:0] z, input logic l, input logic c);
    if_m.in_valid = v; if_m.in_z = z; if_m.in_last = l; if_m.in_clear = c;
    if_s.in_valid = v; if_s.in_z = z; if_s.in_last = l; if_s.in_clear = c;
    if_w.in_valid = v; if_w.in_z = z; if_w.in_last = l; if_w.in_clear = c;
    if_c.in_valid = v; if_c.in_z = z; if_c.in_last = l; if_c.in_clear = c;
  endtask

  task automatic set_ready(input logic r);
    if_m.out_ready = r; if_s.out_ready = r; if_w.out_ready = r; if_c.out_ready = r;
  endtask

  // Offer one beat until it is taken at a clock edge; returns at posedge+1
  task automatic beat(input logic [2:0] z, input logic l, input logic c);
    bit taken;
    taken = 1'b0;
    drive(1'b1, z, l, c);
    for (int i = 0; i < 20 && !taken; i++) begin
      taken = if_m.in_ready;
      @(posedge clk); #1;
    end
    if (!taken) begin
      n_checks++;
      n_fail++;
      $display("FAIL beat_timeout: got in_ready=0 expected 1 within 20 cycles");
    end
    drive(1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (if_m.in_ready && !if_m.out_valid) done = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: got out_valid=%0d expected return to idle", if_m.out_valid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    drive(1'b0, 3'd0, 1'b0, 1'b0);
    set_ready(1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  32'(if_m.in_ready), 32'd1);
    chk("rst_out_valid", 32'(if_m.out_valid), 32'd0);
    chk("rst_out_sum",   32'(if_m.out_sum), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset asserted mid-frame (acc=9) discards the partial frame
    beat(3'd4, 1'b0, 1'b0);
    beat(3'd5, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready",  32'(if_m.in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(if_m.out_valid), 32'd0);
    chk("mid_rst_out_beats", 32'(if_m.out_beats), 32'd0);
    chk("mid_rst_out_ovf",   32'(if_m.out_ovf), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    push_exp(mk(3, 1, 0), mk(3, 1, 0), mk(3, 1, 0), mk(3, 1, 0));
    beat(3'd3, 1'b1, 1'b0);
    wait_idle();

    // Frame 7,5,0,2 under backpressure, with a clear and a beat offered in HOLD
    set_ready(1'b0);
    push_exp(mk(14, 4, 0), mk(14, 4, 0), mk(14, 4, 0), mk(14, 3, 0));
    beat(3'd7, 1'b0, 1'b0);
    beat(3'd5, 1'b0, 1'b0);
    beat(3'd0, 1'b0, 1'b0);
    beat(3'd2, 1'b1, 1'b0);
    chk("lat_out_valid", 32'(if_m.out_valid), 32'd1);
    chk("hold_in_ready", 32'(if_m.in_ready), 32'd0);
    drive(1'b1, 3'd3, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", 32'(if_m.out_valid), 32'd1);
      chk("bp_in_ready",  32'(if_m.in_ready), 32'd0);
      chk("bp_out_sum",   32'(if_m.out_sum), 32'd14);
      chk("bp_c_beats",   32'(if_c.out_beats), 32'd3);
    end
    drive(1'b0, 3'd0, 1'b0, 1'b0);
    set_ready(1'b1);
    @(posedge clk); #1;
    chk("rel_out_valid", 32'(if_m.out_valid), 32'd0);
    chk("rel_in_ready",  32'(if_m.in_ready), 32'd1);

    // Overflow: SUM_W=4 saturates to 15 or wraps to 5
    push_exp(mk(21, 3, 0), mk(15, 3, 1), mk(5, 3, 1), mk(21, 3, 0));
    beat(3'd7, 1'b0, 1'b0);
    beat(3'd7, 1'b0, 1'b0);
    beat(3'd7, 1'b1, 1'b0);
    wait_idle();

    // Overflow stays sticky after a carry-free beat
    push_exp(mk(22, 4, 0), mk(15, 4, 1), mk(6, 4, 1), mk(22, 3, 0));
    beat(3'd7, 1'b0, 1'b0);
    beat(3'd7, 1'b0, 1'b0);
    beat(3'd7, 1'b0, 1'b0);
    beat(3'd1, 1'b1, 1'b0);
    wait_idle();

    // Clear wins over last; nothing may appear, next frame starts from zero
    beat(3'd4, 1'b0, 1'b0);
    beat(3'd6, 1'b0, 1'b0);
    beat(3'd1, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("clr_out_valid", 32'(if_m.out_valid), 32'd0);
    chk("clr_in_ready",  32'(if_m.in_ready), 32'd1);
    push_exp(mk(2, 1, 0), mk(2, 1, 0), mk(2, 1, 0), mk(2, 1, 0));
    beat(3'd2, 1'b1, 1'b0);
    wait_idle();

    // Five beats of 1: beat counter saturates at 3 when CNT_W=2
    push_exp(mk(5, 5, 0), mk(5, 5, 0), mk(5, 5, 0), mk(5, 3, 0));
    for (int i = 0; i < 4; i++) beat(3'd1, 1'b0, 1'b0);
    beat(3'd1, 1'b1, 1'b0);
    wait_idle();

    // Partial frame idles between beats
    push_exp(mk(7, 2, 0), mk(7, 2, 0), mk(7, 2, 0), mk(7, 2, 0));
    beat(3'd6, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("gap_out_valid", 32'(if_m.out_valid), 32'd0);
    beat(3'd1, 1'b1, 1'b0);
    wait_idle();

    repeat (2) @(posedge clk);
    #1;
    chk("q_m_drained", 32'(q_m.size()), 32'd0);
    chk("q_s_drained", 32'(q_s.size()), 32'd0);
    chk("q_w_drained", 32'(q_w.size()), 32'd0);
    chk("q_c_drained", 32'(q_c.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
